shift_arb: RTL and testbench
============================

# shift_arb

Two-requester arbiter and one-deep response stage around the team's combinational 16-bit `shifter` (`in`, `RLamount`, `lui` -> `out`).
- Lets the decode path (requester 0) and the immediate/LUI path (requester 1) share a single shifter instance.
- Uses valid/ready on both request sides and on the response side.
- Registers the result with a requester tag, decoupling shifter timing from consumers.

## Interface
- `DW`, 16, data width; must match `shifter`.
- `AW`, 5, width of `RLamount`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  reset, active-low, asynchronous assert.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when high with valid.
- `req0_data`, `req1_data`  in  DW  shifter `in` operand.
- `req0_amt`, `req1_amt`  in  AW  shifter `RLamount`, passed unmodified.
- `req0_lui`, `req1_lui`  in  1  shifter `lui`.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  requester that produced `rsp_data`.
- `rsp_data`  out  DW  registered shifter output.
- `xfer_cnt`  out  8  count of accepted requests; wraps 255->0.

## Operation
- Output-slot state machine:
  - `EMPTY` -> `FULL` on accept.
  - `FULL` -> `EMPTY` on `rsp_valid & rsp_ready` with no accept.
  - `FULL` -> `FULL` on drain plus accept in the same cycle.
- `can_accept = (state==EMPTY) | rsp_ready`.
- Arbitration is combinational from the valids and the priority state; `grant` is one-hot or zero.
  - One requester valid: that requester is granted.
  - Both valid: the winner follows the priority rule (see Configuration).
- `reqN_ready = can_accept & grant[N]`; a non-granted requester sees ready low and must hold its request stable.
- Shifter operands are muxed from the granted requester. When idle, requester 0's fields drive the shifter (result is don't-care).
- On accept:
  - `rsp_data` <= shifter `out`.
  - `rsp_id` <= granted index.
  - `xfer_cnt` += 1.
- `rsp_data` and `rsp_id` hold stable while `rsp_valid & !rsp_ready`.
- `reqN_ready` may depend on `reqN_valid`; requesters must not make valid depend on ready.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `xfer_cnt`=0, state `EMPTY`, priority pointer = 1, so requester 0 wins the first contention.
  - `reqN_ready`=0 during reset.
- Latency: accept at edge N -> `rsp_valid`=1 with data after edge N.
- Throughput: 1 transfer/cycle while `rsp_ready` is held high.
- Back-pressure: `FULL & !rsp_ready` -> both readies low; requests stall without loss.
- Simultaneous drain and accept: the new result replaces the old in one edge, and `rsp_valid` stays 1.
- Reset asserted mid-transfer: the pending response is discarded. `rsp_valid` falls asynchronously, and the first post-reset accept is requester 0 if both are valid.
- `xfer_cnt` overflow: 255 + accept -> 0, with no flag.

## Configuration
- Macro: `SHIFT_ARB_RR_EN`.
- Defined: round-robin.
  - A 1-bit pointer records the last granted requester and updates only on an accepted transfer.
  - On contention, the requester other than the pointer wins.
  - Continuous contention alternates 0,1,0,1.
- Undefined: fixed priority, requester 0 always wins contention.
  - No pointer register; requester 1 can starve.
  - Reset behaviour is otherwise identical.

## Structure
- Package `shift_arb_pkg` holds:
  - `DW`, `AW` defaults.
  - State typedef (`EMPTY`, `FULL`).
  - Requester id constants `REQ_DEC`=0, `REQ_IMM`=1.
- Exactly one sub-module: one instance of the existing `shifter`.
- Arbitration, output register and counter are inline.

## Test plan
- Reset, then `req0_valid` with data 0x8001, amt 0, lui 0, `rsp_ready`=1 -> next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_data`=0x8001, `xfer_cnt`=1.
- Both requesters valid for 4 cycles, `rsp_ready`=1, RR build:
  - `rsp_id` sequence 0,1,0,1; `xfer_cnt`=4.
  - Fixed build: 0,0,0,0 with `req1_ready` never high.
- One response pending, `rsp_ready`=0 for 3 cycles with both requesters valid:
  - Both readies stay low; `rsp_data`/`rsp_id` stay stable.
  - Raising `rsp_ready` drains and accepts in the same edge.
- Compare `rsp_data` against the shifter reference model for every combination: both requesters × amt 3, 6, 13, 18, 23, 25 × lui 0/1, data 0x8001. No mismatches.
- Assert `reset_n` low while FULL:
  - `rsp_valid` drops without waiting for a clock edge.
  - After release with both valid, the first grant is requester 0.
- Run 256 accepts -> `xfer_cnt` returns to 0.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Purpose : shared constants and types for the shift_arb slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default data/amount widths, the output-slot state type and
// the requester id constants used by shift_arb and its testbench.
package shift_arb_pkg;

    localparam int DW_DEFAULT = 16;   // must match the shifter datapath
    localparam int AW_DEFAULT = 5;    // width of the shifter RLamount

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic REQ_DEC = 1'b0;  // decode path
    localparam logic REQ_IMM = 1'b1;  // immediate / LUI path

endpackage

// File: rtl/shift_arb_shifter.sv
// Purpose : combinational 16-bit shifter shared by the shift_arb requesters.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   in       [15:0] operand
//   RLamount [4:0]  two's-complement shift amount: >=0 shifts left,
//                   <0 shifts right (logical) by the magnitude
//   lui             load-upper: out = {in[7:0], 8'h00}, RLamount ignored
//   out      [15:0] result
module shifter (
    input  logic [15:0] in,
    input  logic [4:0]  RLamount,
    input  logic        lui,
    output logic [15:0] out
);

    logic [4:0] right_amt;

    // Magnitude of a negative amount; only used when RLamount[4] is set.
    assign right_amt = 5'd0 - RLamount;

    always_comb begin
        out = '0;
        if (lui) begin
            out = {in[7:0], 8'h00};
        end else if (RLamount[4]) begin
            out = in >> right_amt;
        end else begin
            out = in << RLamount[3:0];
        end
    end

endmodule

// File: rtl/shift_arb.sv
// Purpose : two-requester arbiter + one-deep registered response around one shifter.
// Latency : accept on edge N, rsp_valid/rsp_data/rsp_id presented right after edge N.
// Backpressure: slot FULL and rsp_ready low forces both req readies low; requests hold.
//
// Ports:
//   clk, reset_n (async active-low)
//   req{0,1}_valid/ready, req{0,1}_data [DW], req{0,1}_amt [AW], req{0,1}_lui
//   rsp_valid/ready, rsp_id, rsp_data [DW]
//   xfer_cnt [8] : accepted-request count, wraps 255 -> 0
//
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 has fixed priority.
module shift_arb
    import shift_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic [AW-1:0] req0_amt,
    input  logic          req0_lui,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    input  logic [AW-1:0] req1_amt,
    input  logic          req1_lui,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,

    output logic [7:0]    xfer_cnt
);

    state_t        state;
    logic          can_accept;
    logic [1:0]    grant;
    logic          accept;
    logic          gnt_id;

    logic [DW-1:0] sh_in;
    logic [AW-1:0] sh_amt;
    logic          sh_lui;
    logic [DW-1:0] sh_out;

    // Slot can take a new result when empty or when it drains this edge.
    assign can_accept = (state == EMPTY) | rsp_ready;

`ifdef SHIFT_ARB_RR_EN
    // Last granted requester; contention goes to the other one.
    logic last_gnt;

    always_comb begin
        grant = 2'b00;
        if (req0_valid && req1_valid) begin
            grant = last_gnt ? 2'b01 : 2'b10;
        end else if (req0_valid) begin
            grant = 2'b01;
        end else if (req1_valid) begin
            grant = 2'b10;
        end
    end

    // Reset value 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= REQ_IMM;
        end else if (accept) begin
            last_gnt <= gnt_id;
        end
    end
`else
    // Fixed priority: requester 0 always wins.
    always_comb begin
        grant = 2'b00;
        if (req0_valid) begin
            grant = 2'b01;
        end else if (req1_valid) begin
            grant = 2'b10;
        end
    end
`endif

    // reset_n gating keeps both readies low while reset is held.
    assign req0_ready = reset_n & can_accept & grant[0];
    assign req1_ready = reset_n & can_accept & grant[1];
    assign accept     = req0_ready | req1_ready;
    assign gnt_id     = grant[1] ? REQ_IMM : REQ_DEC;

    // Requester 0 drives the shifter whenever requester 1 is not granted.
    assign sh_in  = grant[1] ? req1_data : req0_data;
    assign sh_amt = grant[1] ? req1_amt  : req0_amt;
    assign sh_lui = grant[1] ? req1_lui  : req0_lui;

    shifter u_shifter (
        .in       (sh_in),
        .RLamount (sh_amt),
        .lui      (sh_lui),
        .out      (sh_out)
    );

    // Output-slot FSM with registered response fields and transfer count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
            rsp_id    <= REQ_DEC;
            rsp_data  <= '0;
            xfer_cnt  <= 8'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= FULL;
                        rsp_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (!accept && rsp_ready) begin
                        state     <= EMPTY;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    rsp_valid <= 1'b0;
                end
            endcase

            if (accept) begin
                rsp_data <= sh_out;
                rsp_id   <= gnt_id;
                xfer_cnt <= xfer_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_shift_arb.sv
module tb_shift_arb;
    import shift_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req0_ready, req0_lui;
    logic [15:0] req0_data;
    logic [4:0]  req0_amt;
    logic        req1_valid, req1_ready, req1_lui;
    logic [15:0] req1_data;
    logic [4:0]  req1_amt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
    logic [7:0]  xfer_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    shift_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_lui   (req0_lui),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_lui   (req1_lui),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .xfer_cnt   (xfer_cnt)
    );

    // Arithmetic reference of the shifter: signed amount, left for >=0,
    // logical right for <0; lui moves the low byte to the high byte.
    function automatic logic [15:0] shift_ref(logic [15:0] d, logic [4:0] a, logic l);
        int v;
        int s;
        v = int'(d);
        if (l) return 16'((v % 256) * 256);
        s = (int'(a) >= 16) ? int'(a) - 32 : int'(a);
        if (s >= 0) return 16'((v << s) & 32'hFFFF);
        return 16'(v >> (-s));
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req0_data = '0; req0_amt = '0; req0_lui = 0;
        req1_valid = 0; req1_data = '0; req1_amt = '0; req1_lui = 0;
        rsp_ready  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        req0_valid = 1;
        req1_valid = 1;
        rsp_ready  = 1;
        tick();
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 16'h0 || xfer_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b id=%b d=%h cnt=%0d want 0/0/0000/0",
                     rsp_valid, rsp_id, rsp_data, xfer_cnt);
        end
        idle_inputs();
        reset_n = 1;
        #1;
    endtask

    task automatic test_first();
        req0_valid = 1; req0_data = 16'h8001; req0_amt = 5'd0; req0_lui = 0;
        rsp_ready  = 1;
        #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_ready: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h8001 || xfer_cnt !== 8'd1) begin
            errors++;
            $display("FAIL first_rsp: got v=%b id=%b d=%h cnt=%0d want 1/0/8001/1",
                     rsp_valid, rsp_id, rsp_data, xfer_cnt);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_drain: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_contention();
`ifdef SHIFT_ARB_RR_EN
        int exp_seq[4] = '{0, 1, 0, 1};
`else
        int exp_seq[4] = '{0, 0, 0, 0};
`endif
        logic [15:0] exp_d;
        int r1_seen;
        do_reset();
        r1_seen = 0;
        req0_valid = 1; req0_data = 16'h0003; req0_amt = 5'd1; req0_lui = 0;
        req1_valid = 1; req1_data = 16'h0100; req1_amt = 5'd2; req1_lui = 0;
        rsp_ready  = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (req1_ready) r1_seen++;
            tick();
            exp_d = (exp_seq[i] == 1) ? shift_ref(req1_data, req1_amt, req1_lui)
                                      : shift_ref(req0_data, req0_amt, req0_lui);
            vectors++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != exp_seq[i] || rsp_data !== exp_d) begin
                errors++;
                $display("FAIL contention[%0d]: got v=%b id=%0d d=%h want 1/%0d/%h",
                         i, rsp_valid, rsp_id, rsp_data, exp_seq[i], exp_d);
            end
        end
        vectors++;
        if (xfer_cnt !== 8'd4) begin
            errors++;
            $display("FAIL contention_cnt: got %0d want 4", xfer_cnt);
        end
`ifndef SHIFT_ARB_RR_EN
        vectors++;
        if (r1_seen != 0) begin
            errors++;
            $display("FAIL starve_req1: req1_ready high %0d times want 0", r1_seen);
        end
`endif
        idle_inputs();
        rsp_ready = 1;
        tick();
    endtask

    task automatic test_backpressure();
        logic        exp_id;
        logic [15:0] exp_d;
        logic        win;
        do_reset();
        req0_valid = 1; req0_data = 16'h1234; req0_amt = 5'd4; req0_lui = 0;
        rsp_ready  = 1;
        tick();
        exp_id = 0;
        exp_d  = 16'h2340;
        req0_data = 16'h00F0; req0_amt = 5'd30; req0_lui = 0;
        req1_valid = 1; req1_data = 16'h00AB; req1_amt = 5'd0; req1_lui = 1;
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
            end
            tick();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_d || xfer_cnt !== 8'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%b d=%h cnt=%0d want 1/%b/%h/1",
                         i, rsp_valid, rsp_id, rsp_data, xfer_cnt, exp_id, exp_d);
            end
        end
        // After a requester-0 grant, round-robin hands contention to 1.
`ifdef SHIFT_ARB_RR_EN
        win = 1;
`else
        win = 0;
`endif
        rsp_ready = 1;
        #1;
        vectors++;
        if (req0_ready !== !win || req1_ready !== win) begin
            errors++;
            $display("FAIL bp_release_ready: got %b%b want %b%b", req1_ready, req0_ready, win, !win);
        end
        tick();
        exp_d = win ? shift_ref(16'h00AB, 5'd0, 1'b1) : shift_ref(16'h00F0, 5'd30, 1'b0);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== win || rsp_data !== exp_d || xfer_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bp_drain_accept: got v=%b id=%b d=%h cnt=%0d want 1/%b/%h/2",
                     rsp_valid, rsp_id, rsp_data, xfer_cnt, win, exp_d);
        end
        idle_inputs();
        rsp_ready = 1;
        tick();
    endtask

    task automatic test_shift_sweep();
        int amts[6] = '{3, 6, 13, 18, 23, 25};
        logic [15:0] exp_d;
        rsp_ready = 1;
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 6; a++) begin
                for (int l = 0; l < 2; l++) begin
                    idle_inputs();
                    rsp_ready = 1;
                    if (r == 0) begin
                        req0_valid = 1; req0_data = 16'h8001;
                        req0_amt = 5'(amts[a]); req0_lui = 1'(l);
                    end else begin
                        req1_valid = 1; req1_data = 16'h8001;
                        req1_amt = 5'(amts[a]); req1_lui = 1'(l);
                    end
                    tick();
                    exp_d = shift_ref(16'h8001, 5'(amts[a]), 1'(l));
                    vectors++;
                    if (rsp_valid !== 1'b1 || int'(rsp_id) != r || rsp_data !== exp_d) begin
                        errors++;
                        $display("FAIL sweep r%0d amt%0d lui%0d: got v=%b id=%b d=%h want 1/%0d/%h",
                                 r, amts[a], l, rsp_valid, rsp_id, rsp_data, r, exp_d);
                    end
                end
            end
        end
        idle_inputs();
        rsp_ready = 1;
        tick();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        req1_valid = 1; req1_data = 16'h00FF; req1_amt = 5'd1;
        tick();
        req1_valid = 0;
        vectors++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_fill: got rsp_valid=%b want 1", rsp_valid);
        end
        #2;
        reset_n = 0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || xfer_cnt !== 8'd0) begin
            errors++;
            $display("FAIL areset_async: got v=%b d=%h cnt=%0d want 0/0000/0",
                     rsp_valid, rsp_data, xfer_cnt);
        end
        tick();
        req0_valid = 1; req0_data = 16'h0011;
        req1_valid = 1; req1_data = 16'h0022;
        rsp_ready  = 1;
        reset_n = 1;
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_grant: got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0011) begin
            errors++;
            $display("FAIL areset_first: got v=%b id=%b d=%h want 1/0/0011", rsp_valid, rsp_id, rsp_data);
        end
        idle_inputs();
        rsp_ready = 1;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req0_valid = 1; req0_data = 16'h0001;
        rsp_ready  = 1;
        for (int i = 0; i < 255; i++) tick();
        vectors++;
        if (xfer_cnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got %0d want 255", xfer_cnt);
        end
        tick();
        vectors++;
        if (xfer_cnt !== 8'd0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_0: got cnt=%0d v=%b want 0/1", xfer_cnt, rsp_valid);
        end
        idle_inputs();
        rsp_ready = 1;
        tick();
    endtask

    // Randomised traffic against a transaction-level model of the slot.
    task automatic test_random();
        bit          m_v;
        bit          m_id;
        logic [15:0] m_d;
        int          m_cnt;
        bit          m_last;
        bit          acc0, acc1, can, e0, e1;
        do_reset();
        m_v = 0; m_id = 0; m_d = '0; m_cnt = 0; m_last = 1;
        acc0 = 1; acc1 = 1;
        for (int c = 0; c < 2000; c++) begin
            // A stalled request is held unchanged until accepted.
            if (acc0 || !req0_valid) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_data  = 16'($urandom_range(0, 65535));
                req0_amt   = 5'($urandom_range(0, 31));
                req0_lui   = 1'($urandom_range(0, 1));
            end
            if (acc1 || !req1_valid) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_data  = 16'($urandom_range(0, 65535));
                req1_amt   = 5'($urandom_range(0, 31));
                req1_lui   = 1'($urandom_range(0, 1));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            can = !m_v || rsp_ready;
            e0 = 0; e1 = 0;
            if (can && req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_RR_EN
                if (m_last) e0 = 1; else e1 = 1;
`else
                e0 = 1;
`endif
            end else if (can) begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
            vectors++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b%b want %b%b", c, req1_ready, req0_ready, e1, e0);
            end
            if (e0 || e1) begin
                m_v = 1;
                m_id = e1;
                m_d = e1 ? shift_ref(req1_data, req1_amt, req1_lui)
                         : shift_ref(req0_data, req0_amt, req0_lui);
                m_cnt = (m_cnt + 1) % 256;
                m_last = e1;
            end else if (rsp_ready) begin
                m_v = 0;
            end
            acc0 = e0;
            acc1 = e1;
            tick();
            vectors++;
            if (rsp_valid !== m_v || int'(xfer_cnt) != m_cnt ||
                (m_v && (rsp_id !== m_id || rsp_data !== m_d))) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: got v=%b id=%b d=%h cnt=%0d want %b/%b/%h/%0d",
                         c, rsp_valid, rsp_id, rsp_data, xfer_cnt, m_v, m_id, m_d, m_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_first();
        test_contention();
        test_backpressure();
        test_shift_sweep();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
